// File: rtl/periph_reg_router.sv
// Register-bus router: decodes each request against a runtime rule table, forwards it
// to one slave and terminates misses, disabled slaves and hung accesses with an error.
module periph_reg_router #(
    parameter int NumSlaves     = 5,
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256,
    parameter int ErrCntWidth   = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic                           req_write_i,
    input  logic [DataWidth-1:0]           req_wdata_i,
    input  logic [DataWidth/8-1:0]         req_wstrb_i,
    input  logic                           req_valid_i,
    output logic [DataWidth-1:0]           rsp_rdata_o,
    output logic                           rsp_error_o,
    output logic                           rsp_ready_o,
    output logic [AddrWidth-1:0]           slv_addr_o,
    output logic                           slv_write_o,
    output logic [DataWidth-1:0]           slv_wdata_o,
    output logic [DataWidth/8-1:0]         slv_wstrb_o,
    output logic [NumSlaves-1:0]           slv_valid_o,
    input  logic [NumSlaves*DataWidth-1:0] slv_rdata_i,
    input  logic [NumSlaves-1:0]           slv_error_i,
    input  logic [NumSlaves-1:0]           slv_ready_i,
    input  logic [NumSlaves*AddrWidth-1:0] rule_start_i,
    input  logic [NumSlaves*AddrWidth-1:0] rule_end_i,
    input  logic [NumSlaves-1:0]           slv_en_i,
    output logic                           busy_o,
    output logic                           timeout_o,
    output logic [ErrCntWidth-1:0]         err_cnt_o,
    input  logic                           err_cnt_clr_i
);

    localparam int IdxWidth = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int TmoWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {IDLE, FWD, RESP} state_e;

    state_e               state, state_next;
    logic                 hit;
    logic [IdxWidth-1:0]  hit_idx;
    logic [IdxWidth-1:0]  sel;
    logic [TmoWidth-1:0]  tmo_cnt;
    logic [DataWidth-1:0] rdata_arr [NumSlaves];
    logic                 sel_ready;
    logic                 expire;
    logic                 accept;
    logic                 miss;
    logic                 tmo_hit;
    logic                 err_inc;

    // Walk rules from the top down so the lowest matching index is the last one written.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NumSlaves - 1; i >= 0; i--) begin
            if (slv_en_i[i] &&
                req_addr_i >= rule_start_i[i*AddrWidth +: AddrWidth] &&
                req_addr_i <  rule_end_i[i*AddrWidth +: AddrWidth]) begin
                hit     = 1'b1;
                hit_idx = IdxWidth'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumSlaves; i++) begin
            rdata_arr[i] = slv_rdata_i[i*DataWidth +: DataWidth];
        end
    end

    assign sel_ready = slv_ready_i[sel];
    assign expire    = (TimeoutCycles != 0) && (tmo_cnt == TmoWidth'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid_i) state_next = hit ? FWD : RESP;
            FWD:     if (sel_ready || expire) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A slave response in the expiry cycle takes precedence over the timeout.
    always_comb begin
        accept  = (state == IDLE) && req_valid_i;
        miss    = accept && !hit;
        tmo_hit = (state == FWD) && !sel_ready && expire;
        err_inc = miss || tmo_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_rdata_o <= '0;
            rsp_error_o <= 1'b0;
            rsp_ready_o <= 1'b0;
            slv_addr_o  <= '0;
            slv_write_o <= 1'b0;
            slv_wdata_o <= '0;
            slv_wstrb_o <= '0;
            slv_valid_o <= '0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
            err_cnt_o   <= '0;
            sel         <= '0;
            tmo_cnt     <= '0;
        end else begin
            rsp_ready_o <= 1'b0;
            timeout_o   <= 1'b0;
            busy_o      <= (state_next != IDLE);

            if (accept) begin
                slv_addr_o  <= req_addr_i;
                slv_write_o <= req_write_i;
                slv_wdata_o <= req_wdata_i;
                slv_wstrb_o <= req_wstrb_i;
                sel         <= hit_idx;
                tmo_cnt     <= '0;
                if (hit) begin
                    slv_valid_o <= NumSlaves'(1) << hit_idx;
                end else begin
                    rsp_ready_o <= 1'b1;
                    rsp_error_o <= 1'b1;
                    rsp_rdata_o <= '0;
                end
            end

            if (state == FWD) begin
                if (TimeoutCycles != 0) tmo_cnt <= tmo_cnt + 1'b1;
                if (sel_ready) begin
                    slv_valid_o <= '0;
                    rsp_ready_o <= 1'b1;
                    rsp_rdata_o <= rdata_arr[sel];
                    rsp_error_o <= slv_error_i[sel];
                end else if (expire) begin
                    slv_valid_o <= '0;
                    rsp_ready_o <= 1'b1;
                    rsp_error_o <= 1'b1;
                    rsp_rdata_o <= '0;
                    timeout_o   <= 1'b1;
                end
            end

            if (err_cnt_clr_i)                      err_cnt_o <= '0;
            else if (err_inc && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_periph_reg_router.sv
// Directed bench for periph_reg_router: hit/miss/disable, overlap, timeout race,
// counter saturation and clear, and reset in the middle of a forwarded access.
module tb_periph_reg_router;

    localparam int NS = 5;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TC = 4;
    localparam int EW = 2;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [AW-1:0]    req_addr_i;
    logic             req_write_i;
    logic [DW-1:0]    req_wdata_i;
    logic [SW-1:0]    req_wstrb_i;
    logic             req_valid_i;
    logic [DW-1:0]    rsp_rdata_o;
    logic             rsp_error_o;
    logic             rsp_ready_o;
    logic [AW-1:0]    slv_addr_o;
    logic             slv_write_o;
    logic [DW-1:0]    slv_wdata_o;
    logic [SW-1:0]    slv_wstrb_o;
    logic [NS-1:0]    slv_valid_o;
    logic [NS*DW-1:0] slv_rdata_i;
    logic [NS-1:0]    slv_error_i;
    logic [NS-1:0]    slv_ready_i;
    logic [NS*AW-1:0] rule_start_i;
    logic [NS*AW-1:0] rule_end_i;
    logic [NS-1:0]    slv_en_i;
    logic             busy_o;
    logic             timeout_o;
    logic [EW-1:0]    err_cnt_o;
    logic             err_cnt_clr_i;

    int n_checks = 0;
    int n_fail   = 0;

    periph_reg_router #(
        .NumSlaves(NS), .AddrWidth(AW), .DataWidth(DW),
        .TimeoutCycles(TC), .ErrCntWidth(EW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i), .req_valid_i(req_valid_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o), .rsp_ready_o(rsp_ready_o),
        .slv_addr_o(slv_addr_o), .slv_write_o(slv_write_o), .slv_wdata_o(slv_wdata_o),
        .slv_wstrb_o(slv_wstrb_o), .slv_valid_o(slv_valid_o),
        .slv_rdata_i(slv_rdata_i), .slv_error_i(slv_error_i), .slv_ready_i(slv_ready_i),
        .rule_start_i(rule_start_i), .rule_end_i(rule_end_i), .slv_en_i(slv_en_i),
        .busy_o(busy_o), .timeout_o(timeout_o),
        .err_cnt_o(err_cnt_o), .err_cnt_clr_i(err_cnt_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic set_rule(input int i, input logic [AW-1:0] s, input logic [AW-1:0] e);
        rule_start_i[i*AW +: AW] = s;
        rule_end_i[i*AW +: AW]   = e;
    endtask

    task automatic set_rdata(input int i, input logic [DW-1:0] v);
        slv_rdata_i[i*DW +: DW] = v;
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_addr_i    = '0;
        req_write_i   = 1'b0;
        req_wdata_i   = '0;
        req_wstrb_i   = '0;
        req_valid_i   = 1'b0;
        slv_rdata_i   = '0;
        slv_error_i   = '0;
        slv_ready_i   = '0;
        slv_en_i      = 5'b11111;
        err_cnt_clr_i = 1'b0;
        rule_start_i  = '0;
        rule_end_i    = '0;
        set_rule(0, 64'h1000_0000, 64'h1000_1000);
        set_rule(1, 64'h0000_0800, 64'h0000_1800);
        set_rule(2, 64'h0000_1000, 64'h0000_2000);
        set_rule(3, 64'h2003_0000, 64'h2003_1000);
        set_rule(4, 64'h3000_0000, 64'h3000_0000);
        set_rdata(3, 32'hCAFE_F00D);

        // Reset state
        repeat (2) tick();
        check("rst_rsp_ready", rsp_ready_o, 0);
        check("rst_rsp_error", rsp_error_o, 0);
        check("rst_rsp_rdata", rsp_rdata_o, 0);
        check("rst_slv_valid", slv_valid_o, 0);
        check("rst_slv_addr", slv_addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_err_cnt", err_cnt_o, 0);
        rst_ni = 1'b1;
        tick();

        // Read hit on slave 3, ready at cycle 1
        req_addr_i  = 64'h2003_0010;
        req_valid_i = 1'b1;
        tick();
        check("hit_slv_valid_c1", slv_valid_o, 5'b01000);
        check("hit_slv_addr_c1", slv_addr_o, 64'h2003_0010);
        check("hit_slv_write_c1", slv_write_o, 0);
        check("hit_busy_c1", busy_o, 1);
        check("hit_rsp_ready_c1", rsp_ready_o, 0);
        slv_ready_i = 5'b01000;
        tick();
        check("hit_rsp_ready_c2", rsp_ready_o, 1);
        check("hit_rdata_c2", rsp_rdata_o, 32'hCAFE_F00D);
        check("hit_error_c2", rsp_error_o, 0);
        check("hit_slv_valid_c2", slv_valid_o, 0);
        check("hit_err_cnt", err_cnt_o, 0);
        req_valid_i = 1'b0;
        slv_ready_i = '0;
        tick();
        check("hit_rsp_ready_c3", rsp_ready_o, 0);
        check("hit_busy_c3", busy_o, 0);

        // Unmapped read
        req_addr_i  = 64'h4000_0000;
        req_valid_i = 1'b1;
        tick();
        check("miss_rsp_ready", rsp_ready_o, 1);
        check("miss_error", rsp_error_o, 1);
        check("miss_rdata", rsp_rdata_o, 0);
        check("miss_slv_valid", slv_valid_o, 0);
        check("miss_err_cnt", err_cnt_o, 1);
        req_valid_i = 1'b0;
        tick();

        // Disabled slave 3 decodes as a miss even with its ready held high
        slv_en_i    = 5'b10111;
        slv_ready_i = 5'b01000;
        req_addr_i  = 64'h2003_0010;
        req_valid_i = 1'b1;
        tick();
        check("dis_rsp_ready", rsp_ready_o, 1);
        check("dis_error", rsp_error_o, 1);
        check("dis_slv_valid", slv_valid_o, 0);
        check("dis_err_cnt", err_cnt_o, 2);
        req_valid_i = 1'b0;
        slv_ready_i = '0;
        slv_en_i    = 5'b11111;
        tick();

        // Overlapping rules 1 and 2 at 0x1000: write goes to slave 1
        req_addr_i  = 64'h0000_1000;
        req_write_i = 1'b1;
        req_wdata_i = 32'h1234_5678;
        req_wstrb_i = 4'b0011;
        req_valid_i = 1'b1;
        tick();
        check("ovl_slv_valid_c1", slv_valid_o, 5'b00010);
        check("ovl_slv_write", slv_write_o, 1);
        check("ovl_slv_wdata", slv_wdata_o, 32'h1234_5678);
        check("ovl_slv_wstrb", slv_wstrb_o, 4'b0011);
        slv_ready_i = 5'b00100;
        tick();
        check("ovl_ignore_other_ready", rsp_ready_o, 0);
        check("ovl_slv_valid_c2", slv_valid_o, 5'b00010);
        slv_ready_i = 5'b00010;
        set_rdata(1, 32'hAAAA_5555);
        tick();
        check("ovl_rsp_ready", rsp_ready_o, 1);
        check("ovl_rdata", rsp_rdata_o, 32'hAAAA_5555);
        check("ovl_error", rsp_error_o, 0);
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        slv_ready_i = '0;
        tick();

        // Timeout: slave 0 never ready
        req_addr_i  = 64'h1000_0000;
        req_valid_i = 1'b1;
        for (int j = 1; j <= TC; j++) begin
            tick();
            check($sformatf("tmo_slv_valid_c%0d", j), slv_valid_o, 5'b00001);
            check($sformatf("tmo_rsp_ready_c%0d", j), rsp_ready_o, 0);
            check($sformatf("tmo_pulse_c%0d", j), timeout_o, 0);
        end
        tick();
        check("tmo_rsp_ready", rsp_ready_o, 1);
        check("tmo_error", rsp_error_o, 1);
        check("tmo_pulse", timeout_o, 1);
        check("tmo_rdata", rsp_rdata_o, 0);
        check("tmo_slv_valid_end", slv_valid_o, 0);
        check("tmo_err_cnt", err_cnt_o, 3);
        req_valid_i = 1'b0;
        tick();
        check("tmo_pulse_after", timeout_o, 0);
        check("tmo_busy_after", busy_o, 0);

        // Clear the counter
        err_cnt_clr_i = 1'b1;
        tick();
        err_cnt_clr_i = 1'b0;
        check("clr_err_cnt", err_cnt_o, 0);

        // Ready arriving in the expiry cycle beats the timeout
        req_addr_i  = 64'h1000_0004;
        req_valid_i = 1'b1;
        repeat (TC) tick();
        slv_ready_i = 5'b00001;
        slv_error_i = 5'b00001;
        set_rdata(0, 32'h5A5A_5A5A);
        tick();
        check("race_rsp_ready", rsp_ready_o, 1);
        check("race_error", rsp_error_o, 1);
        check("race_timeout", timeout_o, 0);
        check("race_rdata", rsp_rdata_o, 32'h5A5A_5A5A);
        check("race_err_cnt", err_cnt_o, 0);

        // Back-to-back: next request (start-inclusive address) accepted in the cycle after the response
        slv_ready_i = '0;
        slv_error_i = '0;
        req_addr_i  = 64'h2003_0000;
        tick();
        check("b2b_idle_rsp_ready", rsp_ready_o, 0);
        check("b2b_idle_slv_valid", slv_valid_o, 0);
        tick();
        check("b2b_slv_valid", slv_valid_o, 5'b01000);
        check("b2b_slv_addr", slv_addr_o, 64'h2003_0000);
        slv_ready_i = 5'b01000;
        tick();
        check("b2b_rsp_ready", rsp_ready_o, 1);
        check("b2b_rdata", rsp_rdata_o, 32'hCAFE_F00D);
        req_valid_i = 1'b0;
        slv_ready_i = '0;
        tick();

        // Exclusive end and empty rule both miss
        req_addr_i  = 64'h2003_1000;
        req_valid_i = 1'b1;
        tick();
        check("end_excl_error", rsp_error_o, 1);
        check("end_excl_slv_valid", slv_valid_o, 0);
        check("end_excl_err_cnt", err_cnt_o, 1);
        req_valid_i = 1'b0;
        tick();
        req_addr_i  = 64'h3000_0000;
        req_valid_i = 1'b1;
        tick();
        check("empty_rule_error", rsp_error_o, 1);
        check("empty_rule_err_cnt", err_cnt_o, 2);
        req_valid_i = 1'b0;
        tick();

        // Saturation: five more misses stay at all-ones
        req_addr_i = 64'h4000_0000;
        repeat (5) begin
            req_valid_i = 1'b1;
            tick();
            req_valid_i = 1'b0;
            tick();
        end
        check("sat_err_cnt", err_cnt_o, 3);

        // Clear wins over a coincident increment
        req_valid_i   = 1'b1;
        err_cnt_clr_i = 1'b1;
        tick();
        check("clr_pri_rsp_error", rsp_error_o, 1);
        check("clr_pri_err_cnt", err_cnt_o, 0);
        req_valid_i   = 1'b0;
        err_cnt_clr_i = 1'b0;
        tick();

        // One miss so the counter is non-zero before the reset
        req_valid_i = 1'b1;
        tick();
        check("pre_rst_err_cnt", err_cnt_o, 1);
        req_valid_i = 1'b0;
        tick();

        // Reset at cycle 2 of a pending access to slave 0
        req_addr_i  = 64'h1000_0000;
        req_valid_i = 1'b1;
        repeat (2) tick();
        check("mid_slv_valid_before", slv_valid_o, 5'b00001);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_slv_valid", slv_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_slv_addr", slv_addr_o, 0);
        check("mid_rst_err_cnt", err_cnt_o, 0);
        check("mid_rst_rsp_ready", rsp_ready_o, 0);
        check("mid_rst_rsp_error", rsp_error_o, 0);
        req_valid_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_no_rsp", rsp_ready_o, 0);
        check("post_rst_busy", busy_o, 0);

        // Fresh hit after reset release
        req_addr_i  = 64'h2003_0010;
        req_valid_i = 1'b1;
        tick();
        check("fresh_slv_valid", slv_valid_o, 5'b01000);
        slv_ready_i = 5'b01000;
        tick();
        check("fresh_rsp_ready", rsp_ready_o, 1);
        check("fresh_rdata", rsp_rdata_o, 32'hCAFE_F00D);
        check("fresh_error", rsp_error_o, 0);
        check("fresh_err_cnt", err_cnt_o, 0);
        req_valid_i = 1'b0;
        slv_ready_i = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
